// File: rtl/ex_iter_stage.sv
// ex_iter_stage: execute stage for core_lapido.
// Single-cycle ALU ops (ADD, SUB, AND, OR, PASS) complete in one edge.
// MULU, DIVU and REMU use an iterative engine that takes one step per clock.
// The engine asks ID to hold with stall until the result is ready.
// The EX/MEM register is flushable and carries bubbles while the engine is busy.
module ex_iter_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  localparam int CNT_W = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [2:0]        op,
  input  logic              alu_src_imm,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic [DATA_W-1:0] data_rs,
  input  logic [DATA_W-1:0] data_rt,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] ex_mem_data,
  input  logic [DATA_W-1:0] mem_wb_data,
  input  logic [REG_AW-1:0] rd,
  input  logic              reg_we,
  output logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_res,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_we
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_MULU = 3'd4;
  localparam logic [2:0] OP_DIVU = 3'd5;
  localparam logic [2:0] OP_REMU = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] acc_q;
  logic [2:0]        op_q;
  logic [REG_AW-1:0] rd_q;
  logic              we_q;

  logic [DATA_W-1:0] opA;
  logic [DATA_W-1:0] opB;
  logic [DATA_W-1:0] aluRes;
  logic              isMulti;

  logic [DATA_W-1:0] mulAcc_d;
  logic [DATA_W:0]   remShift;
  logic [DATA_W-1:0] remDiff;
  logic              divGe;
  logic [DATA_W-1:0] doneRes;

  // Operand selection: forwarding muxes for A and B, with the immediate
  // overriding the B path when requested.
  always_comb begin
    opA = data_rs;
    case (fwd_a)
      2'd1:    opA = ex_mem_data;
      2'd2:    opA = mem_wb_data;
      default: opA = data_rs;
    endcase
    opB = data_rt;
    case (fwd_b)
      2'd1:    opB = ex_mem_data;
      2'd2:    opB = mem_wb_data;
      default: opB = data_rt;
    endcase
    if (alu_src_imm) begin
      opB = imm;
    end
  end

  // Single-cycle result. The multi-cycle opcodes return zero here because
  // their result comes from the iterative engine instead.
  always_comb begin
    isMulti = (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
    aluRes  = '0;
    case (op)
      OP_ADD:  aluRes = opA + opB;
      OP_SUB:  aluRes = opA - opB;
      OP_AND:  aluRes = opA & opB;
      OP_OR:   aluRes = opA | opB;
      OP_PASS: aluRes = opB;
      default: aluRes = '0;
    endcase
  end

  // One iteration step for each engine. Multiply consumes the multiplier
  // LSB-first against a left-shifting multiplicand. Restoring division
  // shifts the dividend MSB into the partial remainder and subtracts when it
  // fits. A zero divisor always "fits", giving an all-ones quotient and the
  // dividend as the remainder.
  always_comb begin
    mulAcc_d = acc_q + (b_q[0] ? a_q : '0);
    remShift = {acc_q, a_q[DATA_W-1]};
    divGe    = (remShift >= {1'b0, b_q});
    remDiff  = remShift[DATA_W-1:0] - b_q;
    doneRes  = (op_q == OP_DIVU) ? a_q : acc_q;
  end

  // Stall while a multi op waits for acceptance or while the engine is
  // iterating. Reset forces the stall low immediately.
  assign stall = !rst &&
                 (((state_q == S_IDLE) && in_valid && isMulti) || (state_q == S_BUSY));

  // Iterative engine FSM. Operands are captured at acceptance so forwarding
  // changes during BUSY have no effect. Flush discards any partial work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      op_q    <= OP_ADD;
      rd_q    <= '0;
      we_q    <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && isMulti) begin
            a_q     <= opA;
            b_q     <= opB;
            acc_q   <= '0;
            op_q    <= op;
            rd_q    <= rd;
            we_q    <= reg_we;
            cnt_q   <= '0;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (op_q == OP_MULU) begin
            acc_q <= mulAcc_d;
            a_q   <= {a_q[DATA_W-2:0], 1'b0};
            b_q   <= {1'b0, b_q[DATA_W-1:1]};
          end else begin
            acc_q <= divGe ? remDiff : remShift[DATA_W-1:0];
            a_q   <= {a_q[DATA_W-2:0], divGe};
          end
          if (cnt_q == LAST_STEP) begin
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // EX/MEM output register. Bubbles on flush or stall. The engine result
  // retires from DONE. A single-cycle op retires directly. Otherwise a
  // bubble is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_rd    <= '0;
      out_we    <= 1'b0;
    end else if (flush || stall) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_rd    <= '0;
      out_we    <= 1'b0;
    end else if (state_q == S_DONE) begin
      out_valid <= 1'b1;
      out_res   <= doneRes;
      out_rd    <= rd_q;
      out_we    <= we_q;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      out_res   <= aluRes;
      out_rd    <= rd;
      out_we    <= reg_we;
    end else begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_rd    <= '0;
      out_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_iter_stage.sv
// tb_ex_iter_stage: directed test of ex_iter_stage.
// Drives a 32-bit instance and an 8-bit instance with hand-computed vectors.
module tb_ex_iter_stage;

  localparam int W = 32;

  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] SUB  = 3'd1;
  localparam logic [2:0] ANDO = 3'd2;
  localparam logic [2:0] ORO  = 3'd3;
  localparam logic [2:0] MULU = 3'd4;
  localparam logic [2:0] DIVU = 3'd5;
  localparam logic [2:0] REMU = 3'd6;
  localparam logic [2:0] PASS = 3'd7;

  logic clk = 1'b0;
  logic rst;

  logic        flush;
  logic        inValid;
  logic [2:0]  op;
  logic        aluSrcImm;
  logic [1:0]  fwdA;
  logic [1:0]  fwdB;
  logic [31:0] dataRs;
  logic [31:0] dataRt;
  logic [31:0] immV;
  logic [31:0] exMemData;
  logic [31:0] memWbData;
  logic [3:0]  rd;
  logic        regWe;
  logic        stall;
  logic        outValid;
  logic [31:0] outRes;
  logic [3:0]  outRd;
  logic        outWe;

  logic        n8InValid;
  logic [2:0]  n8Op;
  logic [7:0]  n8Rs;
  logic [7:0]  n8Imm;
  logic [7:0]  n8Zero;
  logic [3:0]  n8Rd;
  logic        n8Stall;
  logic        n8OutValid;
  logic [7:0]  n8OutRes;
  logic [3:0]  n8OutRd;
  logic        n8OutWe;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  ex_iter_stage #(.DATA_W(W), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .op(op),
    .alu_src_imm(aluSrcImm), .fwd_a(fwdA), .fwd_b(fwdB),
    .data_rs(dataRs), .data_rt(dataRt), .imm(immV),
    .ex_mem_data(exMemData), .mem_wb_data(memWbData),
    .rd(rd), .reg_we(regWe), .stall(stall), .out_valid(outValid),
    .out_res(outRes), .out_rd(outRd), .out_we(outWe)
  );

  ex_iter_stage #(.DATA_W(8), .REG_AW(4)) dut8 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(n8InValid), .op(n8Op),
    .alu_src_imm(1'b1), .fwd_a(2'd0), .fwd_b(2'd0),
    .data_rs(n8Rs), .data_rt(n8Zero), .imm(n8Imm),
    .ex_mem_data(n8Zero), .mem_wb_data(n8Zero),
    .rd(n8Rd), .reg_we(1'b1), .stall(n8Stall), .out_valid(n8OutValid),
    .out_res(n8OutRes), .out_rd(n8OutRd), .out_we(n8OutWe)
  );

  // Single comparison point: counts and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive the full input set of the 32-bit instance.
  task automatic applyStimulus(input logic v, input logic [2:0] o,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [31:0] im, input logic srcImm,
                               input logic [1:0] fa, input logic [1:0] fb,
                               input logic [31:0] exm, input logic [31:0] mwb,
                               input logic [3:0] d, input logic we);
    inValid   = v;
    op        = o;
    dataRs    = rs;
    dataRt    = rt;
    immV      = im;
    aluSrcImm = srcImm;
    fwdA      = fa;
    fwdB      = fb;
    exMemData = exm;
    memWbData = mwb;
    rd        = d;
    regWe     = we;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, ADD, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0, 2'd0,
                  32'h0, 32'h0, 4'd0, 1'b0);
  endtask

  task automatic checkResult(input string tag, input logic [31:0] res,
                             input logic [3:0] d, input logic we);
    checkOutput({tag, " valid"}, {31'b0, outValid}, 32'd1);
    checkOutput({tag, " res"}, outRes, res);
    checkOutput({tag, " rd"}, {28'b0, outRd}, {28'b0, d});
    checkOutput({tag, " we"}, {31'b0, outWe}, {31'b0, we});
  endtask

  task automatic checkBubble(input string tag);
    checkOutput({tag, " valid"}, {31'b0, outValid}, 32'd0);
    checkOutput({tag, " res"}, outRes, 32'd0);
    checkOutput({tag, " rd"}, {28'b0, outRd}, 32'd0);
    checkOutput({tag, " we"}, {31'b0, outWe}, 32'd0);
  endtask

  // Present a multi op (A via rs, B via imm), count stall cycles and bubbles,
  // then check the retired result. Optionally disturbs the operand inputs
  // after acceptance to show they were latched.
  task automatic runMulti(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] d, input logic [31:0] expected,
                          input logic scramble);
    int cycles = 0;
    int bad    = 0;
    applyStimulus(1'b1, o, a, 32'hDEAD_0000, b, 1'b1, 2'd0, 2'd0,
                  32'h1111_1111, 32'h2222_2222, d, 1'b1);
    #1;
    while (stall === 1'b1 && cycles < 100) begin
      cycles++;
      @(posedge clk);
      #1;
      if (outValid !== 1'b0) bad++;
      if (scramble) begin
        dataRs = dataRs ^ 32'h5A5A_5A5A;
        immV   = immV ^ 32'h0F0F_0F0F;
      end
    end
    checkOutput({tag, " stall cycles"}, cycles, W + 1);
    checkOutput({tag, " bubbles"}, bad, 32'd0);
    @(posedge clk);
    #1;
    checkResult(tag, expected, d, 1'b1);
  endtask

  task automatic runMulti8(input string tag, input logic [2:0] o,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] expected);
    int cycles = 0;
    n8InValid = 1'b1;
    n8Op      = o;
    n8Rs      = a;
    n8Imm     = b;
    n8Rd      = 4'd3;
    #1;
    while (n8Stall === 1'b1 && cycles < 100) begin
      cycles++;
      @(posedge clk);
      #1;
    end
    checkOutput({tag, " stall cycles"}, cycles, 32'd9);
    @(posedge clk);
    #1;
    checkOutput({tag, " valid"}, {31'b0, n8OutValid}, 32'd1);
    checkOutput({tag, " res"}, {24'b0, n8OutRes}, {24'b0, expected});
    checkOutput({tag, " rd"}, {28'b0, n8OutRd}, 32'd3);
    n8InValid = 1'b0;
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    n8InValid = 1'b0;
    n8Op      = ADD;
    n8Rs      = 8'h0;
    n8Imm     = 8'h0;
    n8Zero    = 8'h0;
    n8Rd      = 4'd0;
    applyIdle();
    repeat (2) @(posedge clk);
    #1;
    checkBubble("reset");
    checkOutput("reset stall", {31'b0, stall}, 32'd0);
    checkOutput("reset n8 valid", {31'b0, n8OutValid}, 32'd0);
    rst = 1'b0;

    // ADD rs + imm
    applyStimulus(1'b1, ADD, 32'd5, 32'd0, 32'd3, 1'b1, 2'd0, 2'd0,
                  32'h0, 32'h0, 4'd2, 1'b1);
    #1;
    checkOutput("add stall pre", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    checkResult("add", 32'd8, 4'd2, 1'b1);
    checkOutput("add stall", {31'b0, stall}, 32'd0);

    // Forwarding variants
    applyStimulus(1'b1, SUB, 32'h100, 32'h200, 32'h0, 1'b0, 2'd1, 2'd2,
                  32'h10, 32'h01, 4'd3, 1'b1);
    @(posedge clk); #1;
    checkResult("sub fwd", 32'h0F, 4'd3, 1'b1);
    applyStimulus(1'b1, SUB, 32'h100, 32'h200, 32'h0, 1'b0, 2'd3, 2'd2,
                  32'h10, 32'h01, 4'd4, 1'b1);
    @(posedge clk); #1;
    checkResult("sub fwd3", 32'hFF, 4'd4, 1'b1);
    applyStimulus(1'b1, ANDO, 32'hF0F0, 32'hFF00, 32'h0, 1'b0, 2'd0, 2'd0,
                  32'h10, 32'h01, 4'd5, 1'b0);
    @(posedge clk); #1;
    checkResult("and", 32'hF000, 4'd5, 1'b0);
    applyStimulus(1'b1, ORO, 32'hF0F0, 32'hFF00, 32'h0, 1'b0, 2'd0, 2'd3,
                  32'h10, 32'h01, 4'd6, 1'b1);
    @(posedge clk); #1;
    checkResult("or", 32'hFFF0, 4'd6, 1'b1);
    applyStimulus(1'b1, PASS, 32'h5555, 32'h9999, 32'h1234, 1'b1, 2'd2, 2'd1,
                  32'h10, 32'h01, 4'd7, 1'b1);
    @(posedge clk); #1;
    checkResult("pass", 32'h1234, 4'd7, 1'b1);
    applyStimulus(1'b1, ADD, 32'hFFFF_FFFF, 32'h7, 32'h0, 1'b0, 2'd0, 2'd1,
                  32'h1, 32'h2, 4'd8, 1'b1);
    @(posedge clk); #1;
    checkResult("add wrap", 32'h0, 4'd8, 1'b1);

    // Invalid and flushed single-cycle ops become bubbles
    applyStimulus(1'b0, ADD, 32'd5, 32'd0, 32'd3, 1'b1, 2'd0, 2'd0,
                  32'h0, 32'h0, 4'd2, 1'b1);
    @(posedge clk); #1;
    checkBubble("invalid");
    applyStimulus(1'b1, ADD, 32'd5, 32'd0, 32'd3, 1'b1, 2'd0, 2'd0,
                  32'h0, 32'h0, 4'd2, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkBubble("flush add");

    // Iterative ops, back-to-back
    runMulti("mulu 7x6", MULU, 32'd7, 32'd6, 4'd1, 32'd42, 1'b1);
    runMulti("mulu max x2", MULU, 32'hFFFF_FFFF, 32'd2, 4'd2, 32'hFFFF_FFFE, 1'b0);
    runMulti("divu 100/7", DIVU, 32'd100, 32'd7, 4'd3, 32'd14, 1'b1);
    runMulti("remu 100/7", REMU, 32'd100, 32'd7, 4'd4, 32'd2, 1'b0);
    runMulti("divu 9/0", DIVU, 32'd9, 32'd0, 4'd5, 32'hFFFF_FFFF, 1'b0);
    runMulti("remu 9/0", REMU, 32'd9, 32'd0, 4'd6, 32'd9, 1'b0);
    applyIdle();
    @(posedge clk); #1;
    checkBubble("idle after multi");

    // Flush on the 10th BUSY cycle of a MULU
    applyStimulus(1'b1, MULU, 32'd7, 32'd0, 32'd6, 1'b1, 2'd0, 2'd0,
                  32'h0, 32'h0, 4'd7, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("flush busy stall", {31'b0, stall}, 32'd1);
    flush   = 1'b1;
    inValid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    checkBubble("flush mulu");
    checkOutput("flush stall after", {31'b0, stall}, 32'd0);
    applyStimulus(1'b1, ADD, 32'd2, 32'd2, 32'd0, 1'b0, 2'd0, 2'd0,
                  32'h0, 32'h0, 4'd8, 1'b1);
    @(posedge clk); #1;
    checkResult("add after flush", 32'd4, 4'd8, 1'b1);
    runMulti("mulu after flush", MULU, 32'd3, 32'd5, 4'd9, 32'd15, 1'b0);

    // Reset in the middle of a DIVU
    applyStimulus(1'b1, DIVU, 32'd100, 32'd0, 32'd7, 1'b1, 2'd0, 2'd0,
                  32'h0, 32'h0, 4'd10, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst mid stall", {31'b0, stall}, 32'd0);
    checkBubble("rst mid");
    applyIdle();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkBubble("after rst");
    runMulti("divu after rst", DIVU, 32'd100, 32'd7, 4'd11, 32'd14, 1'b0);
    applyIdle();

    // Narrow instance
    runMulti8("w8 divu 200/3", DIVU, 8'd200, 8'd3, 8'd66);
    runMulti8("w8 remu 200/3", REMU, 8'd200, 8'd3, 8'd2);
    runMulti8("w8 mulu 20x13", MULU, 8'd20, 8'd13, 8'd4);
    runMulti8("w8 divu 5/0", DIVU, 8'd5, 8'd0, 8'hFF);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ex_iter_stage.md
# ex_iter_stage

Parametrised execute stage for the core_lapido pipeline: single-cycle ALU operations plus an iterative unsigned multiplier/divider, with operand forwarding, a stall handshake back to ID, and a flushable EX/MEM output register. It sits between the ID/EX register and the MEM stage. It replaces the fixed-width, single-cycle-only execute datapath for cores that need MUL/DIV without a combinational array.

## Interface
Parameters:
- DATA_W, 32: datapath width (operands, immediate, result); ≥ 4.
- REG_AW, 4: register address width.
- CNT_W, $clog2(DATA_W)+1: iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  branch taken in MEM; kills the instruction in EX.
- in_valid  in  1  ID/EX holds a real instruction.
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 MULU (low DATA_W bits), 5 DIVU quotient, 6 REMU, 7 PASS op2.
- alu_src_imm  in  1  op2 = imm instead of forwarded rt.
- fwd_a, fwd_b  in  2 each  0 register file data, 1 EX/MEM data, 2 MEM/WB data, 3 register file data.
- data_rs, data_rt, imm, ex_mem_data, mem_wb_data  in  DATA_W each  operand sources.
- rd  in  REG_AW  destination register.
- reg_we  in  1  instruction writes the register file.
- stall  out  1  ID/EX and earlier stages must hold.
- out_valid  out  1  EX/MEM holds a real result.
- out_res  out  DATA_W  result.
- out_rd  out  REG_AW  destination.
- out_we  out  1  register write enable (0 whenever out_valid = 0).

## Operation
- Operand A = fwd_a select; operand B = imm if alu_src_imm, else fwd_b select. All arithmetic is modulo 2^DATA_W; ADD/SUB carry is discarded.
- Ops 0–3 and 7 are single-cycle: stall = 0 and the output register loads the result at the next edge.
- Ops 4–6 (multi) use an FSM with states IDLE, BUSY, DONE:
  - IDLE: if in_valid and multi and !flush, latch A, B, op, rd, reg_we, set count = 0, go to BUSY.
  - BUSY: perform one shift-add step (MUL) or restoring-division step (DIV/REM) per edge. After DATA_W steps (count = DATA_W-1 on the edge), go to DONE.
  - DONE: result is available internally; the next edge loads the output register and returns to IDLE.
- stall = (IDLE and in_valid and multi) or BUSY. Stall is 0 in DONE, so ID advances on the same edge that the result is written.
- While stall = 1, the output register loads a bubble (out_valid = 0, out_we = 0, out_res = 0, out_rd = 0).
- Operands are latched at acceptance, so forwarding-input changes during BUSY have no effect.
- Divide by zero: quotient = all ones; remainder = dividend. No trap.
- in_valid = 0: bubble loaded, FSM unchanged.
- flush (synchronous, highest priority after rst): the output register loads a bubble and the FSM goes to IDLE from any state, discarding partial results. stall is 0 in the cycle after the flush edge unless a new multi op is presented.

## Timing
- Reset: out_valid = 0, out_we = 0, out_res = 0, out_rd = 0, FSM = IDLE, count = 0, stall = 0 (combinationally, since the FSM is IDLE).
- Single-cycle op latency: 1 edge.
- Multi op presented in cycle C0: accepted at edge E0, BUSY for DATA_W edges, DONE during cycle C(DATA_W+1), result at edge E(DATA_W+1).
  - Total: DATA_W+2 edges from presentation to result.
  - stall is high for exactly DATA_W+1 cycles.
- Back-to-back multi ops: the second is presented in the cycle after DONE and is accepted at that edge. There is no extra bubble beyond stall.
- rst mid-operation: immediate return to reset values; no partial result emitted.

## Test plan
- Reset, then ADD data_rs = 5, imm = 3, alu_src_imm = 1, rd = 2 -> next edge: out_res = 8, out_rd = 2, out_valid = 1, stall = 0.
- Forwarding: fwd_a = 1, ex_mem_data = 0x10, fwd_b = 2, mem_wb_data = 0x01, SUB -> out_res = 0xF. Repeat with fwd_a = 3 -> uses data_rs.
- MULU 7×6, DATA_W = 32 -> stall high 33 cycles, out_res = 42 on the 34th edge. Output register shows bubbles meanwhile. Then 0xFFFFFFFF×2 -> 0xFFFFFFFE.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
- flush asserted on the 10th BUSY cycle of a MULU -> bubble out, FSM IDLE, stall 0 next cycle. A following ADD completes normally in 1 edge.
- rst asserted mid-DIVU -> all outputs 0 at once. Rerun with DATA_W = 8: 200/3 -> 66, stall 9 cycles.
